// File: rtl/ldpc_posterior_update_if.sv
// Row-level bus between the check-node unit side and the posterior update stage.
// LDPC_POSTERIOR_SAT_CNT_EN adds the o_sat_count clip counter output.
interface ldpc_posterior_update_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 6
);
  logic [LANES*WIDTH-1:0] i_q_data;
  logic                   i_q_valid;
  logic [LANES*WIDTH-1:0] i_r_data;
  logic                   i_r_valid;
  logic [LANES*WIDTH-1:0] o_l_data;
  logic [LANES-1:0]       o_hard;
  logic                   o_valid;
  logic                   o_iter_done;
  logic                   o_checks_ok;
  logic                   o_overflow;
  logic                   o_underflow;
`ifdef LDPC_POSTERIOR_SAT_CNT_EN
  logic [15:0]            o_sat_count;

  modport master (
    output i_q_data, i_q_valid, i_r_data, i_r_valid,
    input  o_l_data, o_hard, o_valid, o_iter_done, o_checks_ok,
           o_overflow, o_underflow, o_sat_count
  );
  modport slave (
    input  i_q_data, i_q_valid, i_r_data, i_r_valid,
    output o_l_data, o_hard, o_valid, o_iter_done, o_checks_ok,
           o_overflow, o_underflow, o_sat_count
  );
`else
  modport master (
    output i_q_data, i_q_valid, i_r_data, i_r_valid,
    input  o_l_data, o_hard, o_valid, o_iter_done, o_checks_ok,
           o_overflow, o_underflow
  );
  modport slave (
    input  i_q_data, i_q_valid, i_r_data, i_r_valid,
    output o_l_data, o_hard, o_valid, o_iter_done, o_checks_ok,
           o_overflow, o_underflow
  );
`endif
endinterface

// File: rtl/ldpc_posterior_update.sv
// Variable-node posterior update: Q delay FIFO, Q+R saturating add, hard decisions, parity.
// Optional clipped-lane counter enabled by LDPC_POSTERIOR_SAT_CNT_EN.
module ldpc_posterior_update #(
  parameter int WIDTH = 8,
  parameter int LANES = 6,
  parameter int DEPTH = 16,
  parameter int ROWS  = 12
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_flush,
  ldpc_posterior_update_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(ROWS);
  localparam int SW = WIDTH + 1;
  localparam logic [AW:0]           FULL     = (AW+1)'(DEPTH);
  localparam logic [RW-1:0]         LAST_ROW = RW'(ROWS - 1);
  localparam logic signed [SW-1:0]  SAT_HI   = SW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0]  SAT_LO   = -SAT_HI;
  localparam logic [WIDTH-1:0]      HI_W     = WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic [WIDTH-1:0]      LO_W     = -HI_W;

  logic [LANES*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   pop_ok, push_ok;
  logic [LANES*WIDTH-1:0] q_head;
  logic                   overflow, underflow;

  logic [LANES*SW-1:0]    sum_d, s1_sum;
  logic                   s1_valid;

  logic [LANES*WIDTH-1:0] sat_d, l_data;
  logic [LANES-1:0]       hard_d, hard;
  logic                   parity;
  logic signed [SW-1:0]   lane_sum;
  logic                   valid, iter_done, checks_ok, acc;
  logic [RW-1:0]          row;

  // A pop from an empty FIFO reads as zero; a full FIFO still accepts a push when popped.
  always_comb begin
    pop_ok  = bus.i_r_valid && (count != '0);
    push_ok = bus.i_q_valid && ((count != FULL) || pop_ok);
    q_head  = pop_ok ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge i_clock) begin
    if (push_ok && !i_flush) mem[wr_ptr] <= bus.i_q_data;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (i_flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      if (bus.i_q_valid && !push_ok)    overflow  <= 1'b1;
      if (bus.i_r_valid && count == '0) underflow <= 1'b1;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_d[k*SW +: SW] = {q_head[k*WIDTH+WIDTH-1], q_head[k*WIDTH +: WIDTH]}
                        + {bus.i_r_data[k*WIDTH+WIDTH-1], bus.i_r_data[k*WIDTH +: WIDTH]};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_sum   <= '0;
      s1_valid <= 1'b0;
    end else if (i_flush) begin
      s1_sum   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= bus.i_r_valid;
      if (bus.i_r_valid) s1_sum <= sum_d;
    end
  end

  // Clamp symmetrically so the most negative code never leaves this stage.
  always_comb begin
    sat_d    = '0;
    hard_d   = '0;
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = $signed(s1_sum[k*SW +: SW]);
      if (lane_sum > SAT_HI)      sat_d[k*WIDTH +: WIDTH] = HI_W;
      else if (lane_sum < SAT_LO) sat_d[k*WIDTH +: WIDTH] = LO_W;
      else                        sat_d[k*WIDTH +: WIDTH] = lane_sum[WIDTH-1:0];
      hard_d[k] = sat_d[k*WIDTH+WIDTH-1];
    end
    parity = ^hard_d;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      l_data    <= '0;
      hard      <= '0;
      valid     <= 1'b0;
      iter_done <= 1'b0;
      checks_ok <= 1'b0;
      acc       <= 1'b1;
      row       <= '0;
    end else if (i_flush) begin
      l_data    <= '0;
      hard      <= '0;
      valid     <= 1'b0;
      iter_done <= 1'b0;
      checks_ok <= 1'b0;
      acc       <= 1'b1;
      row       <= '0;
    end else begin
      valid     <= s1_valid;
      iter_done <= s1_valid && (row == LAST_ROW);
      if (s1_valid) begin
        l_data <= sat_d;
        hard   <= hard_d;
        if (row == LAST_ROW) begin
          row       <= '0;
          checks_ok <= acc & ~parity;
          acc       <= 1'b1;
        end else begin
          row <= row + 1'b1;
          acc <= acc & ~parity;
        end
      end
    end
  end

`ifdef LDPC_POSTERIOR_SAT_CNT_EN
  logic [15:0] sat_count;
  logic [16:0] sat_sum;
  int          n_clip;

  always_comb begin
    n_clip = 0;
    for (int k = 0; k < LANES; k++) begin
      if ($signed(s1_sum[k*SW +: SW]) > SAT_HI || $signed(s1_sum[k*SW +: SW]) < SAT_LO)
        n_clip = n_clip + 1;
    end
    sat_sum = {1'b0, sat_count} + 17'(n_clip);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)                  sat_count <= '0;
    else if (i_flush)                sat_count <= '0;
    else if (s1_valid) sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  assign bus.o_sat_count = sat_count;
`endif

  assign bus.o_l_data    = l_data;
  assign bus.o_hard      = hard;
  assign bus.o_valid     = valid;
  assign bus.o_iter_done = iter_done;
  assign bus.o_checks_ok = checks_ok;
  assign bus.o_overflow  = overflow;
  assign bus.o_underflow = underflow;
endmodule

// File: tb/tb_ldpc_posterior_update.sv
// Scoreboard bench for ldpc_posterior_update: queue-based FIFO model and integer saturating add.
module tb_ldpc_posterior_update;
  typedef logic [47:0] row_t;
  typedef struct {
    row_t       l;
    logic [5:0] hard;
    logic       done;
    logic       ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ldpc_posterior_update_if #(.WIDTH(8), .LANES(6)) dut_if ();

  ldpc_posterior_update #(.WIDTH(8), .LANES(6), .DEPTH(16), .ROWS(12)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_flush  (flush),
    .bus      (dut_if)
  );

  int   passed = 0;
  int   total  = 0;
  exp_t exp_q[$];
  row_t fifo_m[$];
  int   row_m = 0;
  logic acc_m = 1'b1;
  logic ovf_m = 1'b0;
  logic unf_m = 1'b0;
  logic ok_m  = 1'b0;
  row_t last_l = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  function automatic row_t lane(input int k, input logic [7:0] v);
    row_t r;
    r = '0;
    r[k*8 +: 8] = v;
    return r;
  endfunction

  task automatic model_clear();
    fifo_m.delete();
    exp_q.delete();
    row_m = 0;
    acc_m = 1'b1;
    ovf_m = 1'b0;
    unf_m = 1'b0;
    ok_m  = 1'b0;
    last_l = '0;
  endtask

  // One clock of stimulus; the model computes the row that must appear two cycles later.
  task automatic step(input logic qv, input row_t qd, input logic rv, input row_t rd);
    row_t qh;
    exp_t e;
    int   a, b, s;
    dut_if.i_q_valid = qv;
    dut_if.i_q_data  = qd;
    dut_if.i_r_valid = rv;
    dut_if.i_r_data  = rd;
    if (rv) begin
      if (fifo_m.size() > 0) qh = fifo_m.pop_front();
      else begin
        qh = '0;
        unf_m = 1'b1;
      end
      e.hard = '0;
      for (int k = 0; k < 6; k++) begin
        a = $signed(qh[k*8 +: 8]);
        b = $signed(rd[k*8 +: 8]);
        s = a + b;
        if (s > 127)  s = 127;
        if (s < -127) s = -127;
        e.l[k*8 +: 8] = 8'(s);
        e.hard[k] = (s < 0);
      end
      e.done = (row_m == 11);
      e.ok   = 1'b0;
      if (e.done) begin
        e.ok  = acc_m & ~(^e.hard);
        ok_m  = e.ok;
        acc_m = 1'b1;
        row_m = 0;
      end else begin
        acc_m = acc_m & ~(^e.hard);
        row_m++;
      end
      last_l = e.l;
      exp_q.push_back(e);
    end
    if (qv) begin
      if (fifo_m.size() < 16) fifo_m.push_back(qd);
      else ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
    dut_if.i_q_valid = 1'b0;
    dut_if.i_r_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_l_data"}, 64'(dut_if.o_l_data), 64'd0);
    chk({tag, "_hard"}, 64'(dut_if.o_hard), 64'd0);
    chk({tag, "_valid"}, 64'(dut_if.o_valid), 64'd0);
    chk({tag, "_iter_done"}, 64'(dut_if.o_iter_done), 64'd0);
    chk({tag, "_checks_ok"}, 64'(dut_if.o_checks_ok), 64'd0);
    chk({tag, "_overflow"}, 64'(dut_if.o_overflow), 64'd0);
    chk({tag, "_underflow"}, 64'(dut_if.o_underflow), 64'd0);
  endtask

  // Flush with live inputs: the flush must win and discard them.
  task automatic do_flush();
    flush = 1'b1;
    dut_if.i_q_valid = 1'b1;
    dut_if.i_q_data  = {$urandom, $urandom};
    dut_if.i_r_valid = 1'b1;
    dut_if.i_r_data  = {$urandom, $urandom};
    @(posedge clk);
    #1;
    flush = 1'b0;
    dut_if.i_q_valid = 1'b0;
    dut_if.i_r_valid = 1'b0;
    model_clear();
  endtask

  function automatic row_t pos_row();
    row_t r;
    for (int k = 0; k < 6; k++) r[k*8 +: 8] = 8'($urandom_range(0, 60));
    return r;
  endfunction

  task automatic run_iteration(input int bad_row);
    row_t q;
    for (int i = 0; i < 12; i++) begin
      q = pos_row();
      if (i == bad_row) q[3*8 +: 8] = 8'hC0;
      step(1'b1, q, 1'b0, '0);
      step(1'b0, '0, 1'b1, pos_row());
    end
    idle(3);
    chk("checks_ok_hold", 64'(dut_if.o_checks_ok), 64'(ok_m));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dut_if.o_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid: got o_valid=1 expected no output, l_data=%h at %0t",
                 dut_if.o_l_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("l_data", 64'(dut_if.o_l_data), 64'(e.l));
        chk("hard", 64'(dut_if.o_hard), 64'(e.hard));
        chk("iter_done", 64'(dut_if.o_iter_done), 64'(e.done));
        if (e.done) chk("checks_ok", 64'(dut_if.o_checks_ok), 64'(e.ok));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    dut_if.i_q_valid = 1'b0;
    dut_if.i_q_data  = '0;
    dut_if.i_r_valid = 1'b0;
    dut_if.i_r_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);

    step(1'b1, lane(0, 8'h10), 1'b0, '0);
    step(1'b0, '0, 1'b1, lane(0, 8'h05));
    idle(4);
    chk("hold_l_data", 64'(dut_if.o_l_data), 64'(last_l));

    step(1'b1, lane(0, 8'h70) | lane(1, 8'h90) | lane(2, 8'h81), 1'b0, '0);
    step(1'b1, lane(3, 8'h80) | lane(4, 8'h7F) | lane(5, 8'h01), 1'b0, '0);
    step(1'b0, '0, 1'b1, lane(0, 8'h20) | lane(1, 8'hE0) | lane(2, 8'h7F));
    step(1'b0, '0, 1'b1, lane(3, 8'h80) | lane(4, 8'h7F) | lane(5, 8'hFE));
    idle(3);

    // Fill past full, then drain in order and pop once more from empty.
    do_flush();
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, lane(0, 8'(i)) | lane(5, 8'(i * 3)), 1'b0, '0);
      if (i == 16) chk("overflow_at_16", 64'(dut_if.o_overflow), 64'(ovf_m));
    end
    chk("overflow_at_17", 64'(dut_if.o_overflow), 64'(ovf_m));
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, '0);
    chk("underflow_after_drain", 64'(dut_if.o_underflow), 64'(unf_m));
    step(1'b0, '0, 1'b1, lane(2, 8'hF0));
    chk("underflow_empty_pop", 64'(dut_if.o_underflow), 64'(unf_m));
    idle(3);

    // Full FIFO with simultaneous push and pop keeps both.
    do_flush();
    for (int i = 0; i < 16; i++) step(1'b1, lane(1, 8'(i + 1)), 1'b0, '0);
    step(1'b1, lane(1, 8'h55), 1'b1, '0);
    chk("overflow_full_pushpop", 64'(dut_if.o_overflow), 64'(ovf_m));
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, lane(4, 8'(i)));
    idle(3);

    do_flush();
    run_iteration(-1);
    run_iteration(5);
    run_iteration(-1);

    // Flush with entries queued and rows in flight.
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'b0, '0);
    step(1'b0, '0, 1'b1, {$urandom, $urandom});
    step(1'b0, '0, 1'b1, {$urandom, $urandom});
    do_flush();
    check_zero("flush");
    idle(4);
    step(1'b1, lane(0, 8'h22) | lane(3, 8'hF8), 1'b0, '0);
    step(1'b0, '0, 1'b1, lane(0, 8'h11) | lane(3, 8'h04));
    idle(3);

    // Asynchronous reset mid-pipeline, checked before the next clock edge.
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'b0, '0);
    step(1'b0, '0, 1'b1, {$urandom, $urandom});
    step(1'b0, '0, 1'b1, {$urandom, $urandom});
    rst_n = 1'b0;
    #2;
    check_zero("async_reset");
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    step(1'b1, lane(2, 8'h40), 1'b0, '0);
    step(1'b0, '0, 1'b1, lane(2, 8'hD0));
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic qv, rv;
      qv = ($urandom_range(0, 99) < 55);
      rv = (fifo_m.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3);
      step(qv, {$urandom, $urandom}, rv, {$urandom, $urandom});
    end
    chk("rand_overflow", 64'(dut_if.o_overflow), 64'(ovf_m));
    chk("rand_underflow", 64'(dut_if.o_underflow), 64'(unf_m));
    idle(5);
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
